// File: rtl/jesd207_fifo_wr_ctrl.sv
// JESD207 RX write-side controller: aligns I/Q samples, packs them into RAM words, tracks WR_PTR/LEVEL.
// Define JESD207_WR_DROP_CNT_EN to add the DROP_CNT dropped-word counter output.
//
// state | meaning
// IDLE  | disabled; partial word discarded, pointers held
// HUNT  | waiting for an I sample to align on
// LOCK  | aligned; packing alternating I/Q samples into the current word
module jesd207_fifo_wr_ctrl #(
    parameter int ADDR_WID = 5,
    parameter int DATA_WID = 64,
    parameter int SAMP_WID = 12,
    parameter int PACK     = 2
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                ENABLE,
    input  logic                RX_VALID,
    input  logic                RX_FRAME,
    input  logic [SAMP_WID-1:0] RX_DATA,
    input  logic [ADDR_WID:0]   RD_PTR,
    input  logic                CLR_OVF,
    output logic                WR_EN,
    output logic [ADDR_WID-1:0] ADDR_WR,
    output logic [DATA_WID-1:0] D,
    output logic [ADDR_WID:0]   WR_PTR,
    output logic [ADDR_WID:0]   LEVEL,
    output logic                FULL,
    output logic                OVERFLOW,
    output logic                FRAME_ERR,
`ifdef JESD207_WR_DROP_CNT_EN
    output logic [15:0]         DROP_CNT,
`endif
    output logic                LOCKED
);

    localparam int NSLOT  = 2 * PACK;
    localparam int CNT_W  = (NSLOT > 2) ? $clog2(NSLOT) : 1;
    localparam int PACK_W = NSLOT * SAMP_WID;
    localparam logic [CNT_W-1:0]  LAST_SLOT = CNT_W'(NSLOT - 1);
    // Asserts while at most one word (two entries) of space remains
    localparam logic [ADDR_WID:0] FULL_THR  = (ADDR_WID + 1)'((1 << ADDR_WID) - 2);

    typedef enum logic [1:0] {IDLE, HUNT, LOCK} state_t;

    state_t              state;
    logic [CNT_W-1:0]    slot;
    logic [PACK_W-1:0]   pack_q;
    logic [PACK_W-1:0]   word_c;
    logic [ADDR_WID:0]   level_c;
    logic                want_i;
    logic                viol;
    logic                word_done;

    always_comb begin
        want_i    = ~slot[0];
        viol      = ENABLE && (state == LOCK) && RX_VALID && (RX_FRAME != want_i);
        word_done = ENABLE && (state == LOCK) && RX_VALID && !RX_FRAME && (slot == LAST_SLOT);
        level_c   = WR_PTR - RD_PTR;
        word_c    = pack_q;
        for (int k = 0; k < NSLOT; k++) begin
            if (slot == CNT_W'(k))
                word_c[k*SAMP_WID +: SAMP_WID] = RX_DATA;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            slot      <= '0;
            pack_q    <= '0;
            WR_EN     <= 1'b0;
            ADDR_WR   <= '0;
            D         <= '0;
            FRAME_ERR <= 1'b0;
            LOCKED    <= 1'b0;
        end else begin
            WR_EN     <= 1'b0;
            FRAME_ERR <= 1'b0;
            if (!ENABLE) begin
                state  <= IDLE;
                slot   <= '0;
                LOCKED <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= HUNT;
                        slot  <= '0;
                    end
                    HUNT: begin
                        if (RX_VALID && RX_FRAME) begin
                            pack_q <= word_c;
                            slot   <= CNT_W'(1);
                            state  <= LOCK;
                            LOCKED <= 1'b1;
                        end
                    end
                    LOCK: begin
                        if (viol) begin
                            FRAME_ERR <= 1'b1;
                            state     <= HUNT;
                            slot      <= '0;
                            LOCKED    <= 1'b0;
                        end else if (word_done) begin
                            slot <= '0;
                            if (!FULL) begin
                                WR_EN   <= 1'b1;
                                D       <= DATA_WID'(word_c);
                                ADDR_WR <= WR_PTR[ADDR_WID-1:0];
                            end
                        end else if (RX_VALID) begin
                            pack_q <= word_c;
                            slot   <= slot + CNT_W'(1);
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        slot   <= '0;
                        LOCKED <= 1'b0;
                    end
                endcase
            end
        end
    end

    // The RAM fills two entries per strobe, so the pointer steps by 2
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            WR_PTR   <= '0;
            LEVEL    <= '0;
            FULL     <= 1'b0;
            OVERFLOW <= 1'b0;
        end else begin
            if (WR_EN)
                WR_PTR <= WR_PTR + (ADDR_WID + 1)'(2);
            LEVEL <= level_c;
            FULL  <= (level_c >= FULL_THR);
            if (word_done && FULL)
                OVERFLOW <= 1'b1;
            else if (CLR_OVF)
                OVERFLOW <= 1'b0;
        end
    end

`ifdef JESD207_WR_DROP_CNT_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            DROP_CNT <= '0;
        else if (word_done && FULL)
            DROP_CNT <= CLR_OVF ? 16'd1 :
                        (DROP_CNT == 16'hFFFF) ? DROP_CNT : DROP_CNT + 16'd1;
        else if (CLR_OVF)
            DROP_CNT <= '0;
    end
`endif

endmodule

// File: tb/tb_jesd207_fifo_wr_ctrl.sv
// Scoreboard bench for jesd207_fifo_wr_ctrl: directed sample streams push expected writes,
// a negedge monitor pops them whenever WR_EN or FRAME_ERR appears.
module tb_jesd207_fifo_wr_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        ENABLE = 1'b0;
    logic        RX_VALID = 1'b0;
    logic        RX_FRAME = 1'b0;
    logic [11:0] RX_DATA = '0;
    logic [5:0]  RD_PTR = '0;
    logic        CLR_OVF = 1'b0;
    logic        WR_EN;
    logic [4:0]  ADDR_WR;
    logic [63:0] D;
    logic [5:0]  WR_PTR;
    logic [5:0]  LEVEL;
    logic        FULL;
    logic        OVERFLOW;
    logic        FRAME_ERR;
    logic        LOCKED;
`ifdef JESD207_WR_DROP_CNT_EN
    logic [15:0] DROP_CNT;
`endif

    typedef struct packed {
        logic [4:0]  addr;
        logic [63:0] data;
    } wr_t;

    wr_t        exp_q[$];
    int         ferr_pend = 0;
    int         n_chk = 0;
    int         n_fail = 0;
    logic [5:0] exp_ptr = '0;

    jesd207_fifo_wr_ctrl #(.ADDR_WID(5), .DATA_WID(64), .SAMP_WID(12), .PACK(2)) dut (
        .CLK(CLK), .RST(RST), .ENABLE(ENABLE), .RX_VALID(RX_VALID), .RX_FRAME(RX_FRAME),
        .RX_DATA(RX_DATA), .RD_PTR(RD_PTR), .CLR_OVF(CLR_OVF), .WR_EN(WR_EN),
        .ADDR_WR(ADDR_WR), .D(D), .WR_PTR(WR_PTR), .LEVEL(LEVEL), .FULL(FULL),
        .OVERFLOW(OVERFLOW), .FRAME_ERR(FRAME_ERR),
`ifdef JESD207_WR_DROP_CNT_EN
        .DROP_CNT(DROP_CNT),
`endif
        .LOCKED(LOCKED)
    );

    always #5 CLK = ~CLK;

    function automatic logic [63:0] pack4(input logic [11:0] a, input logic [11:0] b,
                                          input logic [11:0] c, input logic [11:0] d);
        return {16'h0000, d, c, b, a};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge CLK);
            RX_VALID = 1'b0;
        end
    endtask

    task automatic samp(input logic f, input logic [11:0] d);
        @(negedge CLK);
        RX_VALID = 1'b1;
        RX_FRAME = f;
        RX_DATA  = d;
    endtask

    task automatic expect_wr(input logic [63:0] data);
        wr_t e;
        e.addr = exp_ptr[4:0];
        e.data = data;
        exp_q.push_back(e);
        exp_ptr = exp_ptr + 6'd2;
    endtask

    task automatic word(input logic [11:0] a, input logic [11:0] b, input logic [11:0] c,
                        input logic [11:0] d, input bit wr);
        if (wr) expect_wr(pack4(a, b, c, d));
        samp(1'b1, a);
        samp(1'b0, b);
        samp(1'b1, c);
        samp(1'b0, d);
        tick(1);
    endtask

    // Monitor: every WR_EN must match the oldest expected write; every FRAME_ERR must be expected
    initial begin
        wr_t e;
        forever begin
            @(negedge CLK);
            if (WR_EN) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_wr_en: got addr %0h data %0h expected no write at %0t",
                             ADDR_WR, D, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", 64'(ADDR_WR), 64'(e.addr));
                    chk("wr_data", D, e.data);
                end
            end
            if (FRAME_ERR) begin
                if (ferr_pend == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_frame_err: got 1 expected 0 at %0t", $time);
                end else begin
                    chk("frame_err_pulse", 64'(FRAME_ERR), 64'd1);
                    ferr_pend--;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        tick(2);
        chk("rst_wr_en", 64'(WR_EN), 64'd0);
        chk("rst_addr_wr", 64'(ADDR_WR), 64'd0);
        chk("rst_d", D, 64'd0);
        chk("rst_wr_ptr", 64'(WR_PTR), 64'd0);
        chk("rst_level", 64'(LEVEL), 64'd0);
        chk("rst_full", 64'(FULL), 64'd0);
        chk("rst_overflow", 64'(OVERFLOW), 64'd0);
        chk("rst_frame_err", 64'(FRAME_ERR), 64'd0);
        chk("rst_locked", 64'(LOCKED), 64'd0);
        RST = 1'b0;
        ENABLE = 1'b1;
        tick(2);

        // Lock: first word at address 0
        expect_wr(64'h0000_0040_0300_2001);
        samp(1'b1, 12'h001);
        samp(1'b0, 12'h002);
        chk("lock_locked", 64'(LOCKED), 64'd1);
        samp(1'b1, 12'h003);
        samp(1'b0, 12'h004);
        tick(1);
        chk("lock_wr_en_n1", 64'(WR_EN), 64'd1);
        chk("lock_wr_ptr_hold", 64'(WR_PTR), 64'd0);
        tick(2);
        chk("lock_wr_ptr", 64'(WR_PTR), 64'd2);
        chk("lock_level", 64'(LEVEL), 64'd2);

        // Hunt: leading Q samples and valid gaps are ignored
        ENABLE = 1'b0;
        tick(1);
        chk("idle_unlocked", 64'(LOCKED), 64'd0);
        ENABLE = 1'b1;
        tick(2);
        expect_wr(pack4(12'h101, 12'h102, 12'h103, 12'h104));
        samp(1'b0, 12'h0AA);
        tick(1);
        samp(1'b0, 12'h0BB);
        tick(1);
        chk("hunt_unlocked", 64'(LOCKED), 64'd0);
        samp(1'b1, 12'h101);
        samp(1'b0, 12'h102);
        chk("hunt_locked", 64'(LOCKED), 64'd1);
        tick(1);
        samp(1'b1, 12'h103);
        samp(1'b0, 12'h104);
        tick(1);

        // Violation: I,Q,I,I drops the word, next I relocks
        ferr_pend++;
        samp(1'b1, 12'h111);
        samp(1'b0, 12'h222);
        samp(1'b1, 12'h333);
        samp(1'b1, 12'h444);
        tick(1);
        chk("viol_unlocked", 64'(LOCKED), 64'd0);
        word(12'h555, 12'h666, 12'h777, 12'h888, 1'b1);

        // ENABLE drops in the cycle the word completes
        samp(1'b1, 12'hA01);
        samp(1'b0, 12'hA02);
        samp(1'b1, 12'hA03);
        @(negedge CLK);
        ENABLE   = 1'b0;
        RX_VALID = 1'b1;
        RX_FRAME = 1'b0;
        RX_DATA  = 12'hA04;
        tick(1);
        ENABLE = 1'b1;
        tick(2);
        chk("en_drop_wr_ptr", 64'(WR_PTR), 64'd6);
        chk("en_drop_unlocked", 64'(LOCKED), 64'd0);
        word(12'hB01, 12'hB02, 12'hB03, 12'hB04, 1'b1);

        // RST mid-word clears everything
        samp(1'b1, 12'hC01);
        samp(1'b0, 12'hC02);
        samp(1'b1, 12'hC03);
        @(negedge CLK);
        RX_VALID = 1'b0;
        RST = 1'b1;
        #1;
        chk("rst_mid_wr_ptr", 64'(WR_PTR), 64'd0);
        chk("rst_mid_locked", 64'(LOCKED), 64'd0);
        tick(1);
        chk("rst_mid_level", 64'(LEVEL), 64'd0);
        RST = 1'b0;
        exp_ptr = '0;
        tick(2);

        // Full / overflow with RD_PTR parked at 0
        RD_PTR = 6'd0;
        for (int i = 0; i < 14; i++)
            word(12'(16 * i + 1), 12'(16 * i + 2), 12'(16 * i + 3), 12'(16 * i + 4), 1'b1);
        tick(2);
        chk("full_level_28", 64'(LEVEL), 64'd28);
        chk("full_not_yet", 64'(FULL), 64'd0);
        word(12'hE01, 12'hE02, 12'hE03, 12'hE04, 1'b1);
        tick(2);
        chk("full_level_30", 64'(LEVEL), 64'd30);
        chk("full_set", 64'(FULL), 64'd1);
        chk("full_no_ovf_yet", 64'(OVERFLOW), 64'd0);
        word(12'hF01, 12'hF02, 12'hF03, 12'hF04, 1'b0);
        tick(1);
        chk("ovf_set", 64'(OVERFLOW), 64'd1);
        chk("ovf_wr_ptr", 64'(WR_PTR), 64'd30);
`ifdef JESD207_WR_DROP_CNT_EN
        chk("drop_cnt_1", 64'(DROP_CNT), 64'd1);
`endif
        CLR_OVF = 1'b1;
        tick(1);
        CLR_OVF = 1'b0;
        chk("ovf_cleared", 64'(OVERFLOW), 64'd0);
`ifdef JESD207_WR_DROP_CNT_EN
        chk("drop_cnt_cleared", 64'(DROP_CNT), 64'd0);
`endif
        // Drop and CLR_OVF in the same cycle: set wins
        samp(1'b1, 12'hD01);
        samp(1'b0, 12'hD02);
        samp(1'b1, 12'hD03);
        @(negedge CLK);
        RX_VALID = 1'b1;
        RX_FRAME = 1'b0;
        RX_DATA  = 12'hD04;
        CLR_OVF  = 1'b1;
        tick(1);
        CLR_OVF = 1'b0;
        chk("ovf_set_priority", 64'(OVERFLOW), 64'd1);
`ifdef JESD207_WR_DROP_CNT_EN
        chk("drop_cnt_priority", 64'(DROP_CNT), 64'd1);
`endif

        // Wrap: read side follows, 40 words
        RD_PTR = 6'd30;
        tick(2);
        for (int i = 0; i < 40; i++) begin
            RD_PTR = exp_ptr;
            word(12'(4 * i + 12'h200), 12'(4 * i + 12'h201), 12'(4 * i + 12'h202),
                 12'(4 * i + 12'h203), 1'b1);
            tick(2);
            chk("wrap_level_le2", 64'(LEVEL <= 6'd2), 64'd1);
            if (i == 0) chk("wrap_bit_set", 64'(WR_PTR), 64'd32);
        end
        chk("wrap_final_ptr", 64'(WR_PTR), 64'd46);
        chk("wrap_no_full", 64'(FULL), 64'd0);

        // Final RST clears the sticky overflow
        RST = 1'b1;
        #1;
        chk("rst2_overflow", 64'(OVERFLOW), 64'd0);
        chk("rst2_wr_ptr", 64'(WR_PTR), 64'd0);
        chk("rst2_full", 64'(FULL), 64'd0);
`ifdef JESD207_WR_DROP_CNT_EN
        chk("rst2_drop_cnt", 64'(DROP_CNT), 64'd0);
`endif
        tick(1);
        RST = 1'b0;
        tick(3);

        chk("pending_writes", 64'(exp_q.size()), 64'd0);
        chk("pending_frame_err", 64'(ferr_pend), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
